// File: rtl/div_int_multi.sv
// div_int_multi: iterative signed/unsigned divider retiring STEPS quotient bits per clock
module div_int_multi #(
  parameter int WIDTH = 8,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             valid,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  localparam int ITERS = WIDTH / STEPS;
  localparam int CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  if (WIDTH % STEPS != 0) begin : g_bad
    $error("div_int_multi: WIDTH must be a multiple of STEPS");
  end
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dd, dd_nx, ym, xa, ya;
  logic [WIDTH:0] acc, acc_nx;
  logic qs, rs, zero, ovf_c, go;
  assign zero = y == '0;
  assign ovf_c = sgn && x == {1'b1, {(WIDTH-1){1'b0}}} && &y;
  assign go = state == IDLE && start;
  assign busy = state != IDLE;
  assign xa = sgn && x[WIDTH-1] ? -x : x;
  assign ya = sgn && y[WIDTH-1] ? -y : y;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: trivial requests (y==0, MIN/-1) finish in IDLE without iterating
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start && !zero && !ovf_c ? CALC : IDLE)
             : state == CALC ? (cnt == LAST ? FIX : CALC) : IDLE;
  end
  // STEPS restoring shift/subtract steps, MSB first; quotient bits shift into dd
  always_comb begin
    acc_nx = acc;
    dd_nx = dd;
    for (int i = 0; i < STEPS; i++) begin
      acc_nx = {acc_nx[WIDTH-1:0], dd_nx[WIDTH-1]};
      dd_nx = {dd_nx[WIDTH-2:0], 1'b0};
      if (acc_nx >= {1'b0, ym}) begin
        acc_nx = acc_nx - {1'b0, ym};
        dd_nx[0] = 1'b1;
      end
    end
  end
  // datapath: latch magnitudes on accept, iterate in CALC, apply signs in FIX
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {cnt, dd, ym, acc, qs, rs, q, r, valid, dbz, ovf} <= '0;
    end else if (go) begin
      valid <= 1'b0;
      dbz <= zero;
      ovf <= ovf_c;
      q <= '0;
      r <= '0;
      dd <= xa;
      ym <= ya;
      acc <= '0;
      cnt <= '0;
      qs <= sgn & (x[WIDTH-1] ^ y[WIDTH-1]);
      rs <= sgn & x[WIDTH-1];
    end else if (state == CALC) begin
      acc <= acc_nx;
      dd <= dd_nx;
      cnt <= cnt + CW'(1);
    end else if (state == FIX) begin
      q <= qs ? -dd : dd;
      r <= rs ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      valid <= 1'b1;
    end
endmodule

// File: tb/tb_div_int_multi.sv
// tb_div_int_multi: scoreboard bench exercising STEPS=1 and STEPS=2 dividers in turn
module tb_div_int_multi;
  logic clk = 0, rst_n = 1, start = 0, sgn = 0, cur = 0;
  logic [7:0] x = 0, y = 0;
  logic busy [2], valid [2], dbz [2], ovf [2];
  logic [7:0] q [2], r [2];
  logic busy_m, valid_m, dbz_m, ovf_m;
  logic [7:0] q_m, r_m;
  typedef struct packed {logic [2:0] f; logic [7:0] q; logic [7:0] r;} exp_t;
  exp_t sbq[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  div_int_multi #(.WIDTH(8), .STEPS(1)) u_s1 (.clk(clk), .rst_n(rst_n), .start(start && !cur), .sgn(sgn),
    .x(x), .y(y), .busy(busy[0]), .valid(valid[0]), .dbz(dbz[0]), .ovf(ovf[0]), .q(q[0]), .r(r[0]));
  div_int_multi #(.WIDTH(8), .STEPS(2)) u_s2 (.clk(clk), .rst_n(rst_n), .start(start && cur), .sgn(sgn),
    .x(x), .y(y), .busy(busy[1]), .valid(valid[1]), .dbz(dbz[1]), .ovf(ovf[1]), .q(q[1]), .r(r[1]));
  assign busy_m = busy[cur];
  assign valid_m = valid[cur];
  assign dbz_m = dbz[cur];
  assign ovf_m = ovf[cur];
  assign q_m = q[cur];
  assign r_m = r[cur];
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s (steps=%0d): got %0h expected %0h", nm, cur + 1, a, e);
    end
  endtask
  // monitor: a result is presented when valid rises or an accepted request raised dbz/ovf
  initial begin
    logic pend = 0, pv = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        pv = 0;
      end else begin
        if ((pend && (dbz_m || ovf_m)) || (valid_m && !pv)) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result (steps=%0d): got q=%0h r=%0h expected none", cur + 1, q_m, r_m);
          end else begin
            e = sbq.pop_front();
            chk("flags", {valid_m, dbz_m, ovf_m}, e.f);
            chk("q", q_m, e.q);
            chk("r", r_m, e.r);
          end
        end
        pend = start && !busy_m;
        pv = valid_m;
      end
    end
  end
  task automatic issue(input logic s, input logic [7:0] xv, input logic [7:0] yv,
                       input logic [2:0] f, input logic [7:0] qe, input logic [7:0] re);
    sgn = s;
    x = xv;
    y = yv;
    start = 1;
    sbq.push_back({f, qe, re});
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((busy_m || sbq.size() != 0) && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    if (k == 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout (steps=%0d): got busy=%0b pending=%0d expected idle", cur + 1, busy_m, sbq.size());
      sbq.delete();
    end
  endtask
  task automatic op(input logic s, input logic [7:0] xv, input logic [7:0] yv,
                    input logic [2:0] f, input logic [7:0] qe, input logic [7:0] re);
    issue(s, xv, yv, f, qe, re);
    wait_idle();
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy_m, 0);
    chk({nm, "_valid"}, valid_m, 0);
    chk({nm, "_flags"}, {dbz_m, ovf_m}, 0);
    chk({nm, "_qr"}, {q_m, r_m}, 0);
  endtask
  task automatic run();
    int its;
    int k;
    its = cur ? 4 : 8;
    rst_n = 1;
    #1 rst_n = 0;
    #2 chk_zero("reset");
    @(posedge clk);
    #1 rst_n = 1;
    issue(0, 8'd200, 8'd7, 3'b100, 8'd28, 8'd4);
    chk("busy_e0", busy_m, 1);
    for (int i = 1; i <= its + 1; i++) begin
      @(posedge clk);
      #1 if (i == its) chk("lat_before", {busy_m, valid_m}, 2'b10);
    end
    chk("lat_after", {busy_m, valid_m}, 2'b01);
    wait_idle();
    op(1, 8'hF9, 8'h02, 3'b100, 8'hFD, 8'hFF);
    op(1, 8'h07, 8'hFE, 3'b100, 8'hFD, 8'h01);
    op(1, 8'h80, 8'h01, 3'b100, 8'h80, 8'h00);
    op(0, 8'h80, 8'hFF, 3'b100, 8'h00, 8'h80);
    op(1, 8'h80, 8'h02, 3'b100, 8'hC0, 8'h00);
    op(1, 8'hF9, 8'hFE, 3'b100, 8'h03, 8'hFF);
    op(0, 8'hFF, 8'hFF, 3'b100, 8'h01, 8'h00);
    op(0, 8'h00, 8'h05, 3'b100, 8'h00, 8'h00);
    op(1, 8'h64, 8'hF9, 3'b100, 8'hF2, 8'h02);
    op(0, 8'hFF, 8'h01, 3'b100, 8'hFF, 8'h00);
    op(1, 8'h80, 8'h80, 3'b100, 8'h01, 8'h00);
    op(1, 8'h7F, 8'h80, 3'b100, 8'h00, 8'h7F);
    issue(0, 8'd5, 8'd0, 3'b010, 8'd0, 8'd0);
    chk("dbz_e0", {dbz_m, busy_m, valid_m}, 3'b100);
    wait_idle();
    op(1, 8'h00, 8'h00, 3'b010, 8'd0, 8'd0);
    issue(1, 8'h80, 8'hFF, 3'b001, 8'd0, 8'd0);
    chk("ovf_e0", {ovf_m, busy_m, q_m, r_m}, {2'b10, 16'h0});
    wait_idle();
    issue(0, 8'd200, 8'd7, 3'b100, 8'd28, 8'd4);
    repeat (2) @(posedge clk);
    #1 x = 8'd100;
    y = 8'd3;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_idle();
    chk("ignored_hold", {q_m, r_m}, {8'd28, 8'd4});
    sgn = 0;
    x = 8'd200;
    y = 8'd7;
    start = 1;
    sbq.push_back({3'b100, 8'd28, 8'd4});
    k = 0;
    do begin
      @(posedge clk);
      #1 k++;
    end while (!valid_m && k < 100);
    chk("b2b_first_valid", valid_m, 1);
    x = 8'd13;
    y = 8'd5;
    sbq.push_back({3'b100, 8'd2, 8'd3});
    @(posedge clk);
    #1 chk("b2b_busy", busy_m, 1);
    start = 0;
    wait_idle();
    issue(1, 8'hF9, 8'h02, 3'b100, 8'hFD, 8'hFF);
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    #1 chk_zero("midreset");
    sbq.delete();
    @(posedge clk);
    #1 rst_n = 1;
    op(0, 8'd200, 8'd7, 3'b100, 8'd28, 8'd4);
  endtask
  initial begin
    cur = 0;
    run();
    cur = 1;
    run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
